// File: rtl/lector_adc_temperatura.sv
// Serial ADC reader: periodic 16-clock SPI frame, 8-bit code truncated to a
// 5-bit temperature with one-cycle ready/error pulses.
module lector_adc_temperatura #(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       SDATA,
   output logic       SCLK,
   output logic       CS_n,
   output logic [4:0] Temperatura,
   output logic       DatosListos,
   output logic       ErrorTrama,
   output logic       Ocupado
);

   localparam int PW = $clog2(SAMPLE_PERIOD);
   localparam int DW = $clog2(CLK_DIV);

   typedef enum logic [1:0] {
      REPOSO,
      SETUP,
      TRAMA,
      FIN
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [PW-1:0] per_q, per_d;
   logic [DW-1:0] div_q, div_d;
   logic [4:0]    flancos_q, flancos_d;
   logic [15:0]   sr_q, sr_d;
   logic          sclk_q, sclk_d;
   logic          cs_n_q, cs_n_d;
   logic [4:0]    temp_q, temp_d;
   logic          dl_q, dl_d;
   logic          err_q, err_d;
   logic          ocup_q, ocup_d;

   logic tick;
   logic div_fin;

   assign tick    = (per_q == PW'(SAMPLE_PERIOD - 1));
   assign div_fin = (div_q == DW'(CLK_DIV - 1));

   always_comb begin
      estado_d  = estado_q;
      per_d     = tick ? '0 : per_q + PW'(1);
      div_d     = div_q;
      flancos_d = flancos_q;
      sr_d      = sr_q;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      temp_d    = temp_q;
      dl_d      = 1'b0;
      err_d     = 1'b0;
      unique case (estado_q)
         REPOSO: begin
            sclk_d = 1'b1;
            cs_n_d = 1'b1;
            if (tick) begin
               estado_d = SETUP;
               cs_n_d   = 1'b0;
               div_d    = '0;
            end
         end
         SETUP: begin
            div_d = div_q + DW'(1);
            if (div_fin) begin
               estado_d  = TRAMA;
               div_d     = '0;
               sclk_d    = 1'b0;
               flancos_d = 5'd0;
            end
         end
         TRAMA: begin
            div_d = div_q + DW'(1);
            if (div_fin) begin
               div_d = '0;
               if (!sclk_q) begin
                  // sample on the same edge that raises SCLK
                  sclk_d    = 1'b1;
                  sr_d      = {sr_q[14:0], SDATA};
                  flancos_d = flancos_q + 5'd1;
               end else if (flancos_q == 5'd16) begin
                  estado_d = FIN;
                  sclk_d   = 1'b1;
                  cs_n_d   = 1'b1;
                  if (sr_q[15:13] == 3'b000) begin
                     temp_d = sr_q[12:8];
                     dl_d   = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  sclk_d = 1'b0;
               end
            end
         end
         FIN: begin
            estado_d = REPOSO;
         end
      endcase
      ocup_d = ~cs_n_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         estado_q  <= REPOSO;
         per_q     <= '0;
         div_q     <= '0;
         flancos_q <= 5'd0;
         sr_q      <= 16'd0;
         sclk_q    <= 1'b1;
         cs_n_q    <= 1'b1;
         temp_q    <= 5'd0;
         dl_q      <= 1'b0;
         err_q     <= 1'b0;
         ocup_q    <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         per_q     <= per_d;
         div_q     <= div_d;
         flancos_q <= flancos_d;
         sr_q      <= sr_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         temp_q    <= temp_d;
         dl_q      <= dl_d;
         err_q     <= err_d;
         ocup_q    <= ocup_d;
      end
   end

   assign SCLK        = sclk_q;
   assign CS_n        = cs_n_q;
   assign Temperatura = temp_q;
   assign DatosListos = dl_q;
   assign ErrorTrama  = err_q;
   assign Ocupado     = ocup_q;

endmodule

// File: tb/tb_lector_adc_temperatura.sv
// Directed bench for lector_adc_temperatura with a behavioural ADC model
// per instance (default and CLK_DIV=2 / SAMPLE_PERIOD=70).
module tb_lector_adc_temperatura;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sdata, sclk, cs_n, dl, er, ocup;
   logic [4:0] temp;
   logic       sdata2, sclk2, cs_n2, dl2, er2, ocup2;
   logic [4:0] temp2;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [15:0] frame  = 16'd0;
   logic [15:0] frame2 = {3'b000, 8'h80, 5'b00000};
   int nf  = 0;
   int nr  = 0;
   int nf2 = 0;
   int prev_fall = 0;

   lector_adc_temperatura dut (
      .clk(clk), .rst(rst), .SDATA(sdata), .SCLK(sclk), .CS_n(cs_n),
      .Temperatura(temp), .DatosListos(dl), .ErrorTrama(er), .Ocupado(ocup)
   );

   lector_adc_temperatura #(.CLK_DIV(2), .SAMPLE_PERIOD(70)) dut2 (
      .clk(clk), .rst(rst), .SDATA(sdata2), .SCLK(sclk2), .CS_n(cs_n2),
      .Temperatura(temp2), .DatosListos(dl2), .ErrorTrama(er2), .Ocupado(ocup2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ADC model: new bit after each SCLK fall, first bit after the first fall
   always @(negedge sclk or negedge cs_n)
      if (sclk) nf = 0;
      else nf = nf + 1;
   always @(posedge sclk) if (!cs_n) nr = nr + 1;
   assign sdata = (nf >= 1 && nf <= 16) ? frame[16-nf] : 1'b0;

   always @(negedge sclk2 or negedge cs_n2)
      if (sclk2) nf2 = 0;
      else nf2 = nf2 + 1;
   assign sdata2 = (nf2 >= 1 && nf2 <= 16) ? frame2[16-nf2] : 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_frame(input logic [2:0] lead, input logic [7:0] code,
                           input int refc, input int exp_dl, input int exp_t);
      int fc;
      int r0;
      frame = {lead, code, 5'b00000};
      for (int k = 0; k < 1200; k++) begin
         @(negedge clk);
         if (!cs_n) break;
      end
      fc = cyc;
      r0 = nr;
      chk("fall_gap", fc - refc, 1000);
      chk("ocupado", int'(ocup), 1);
      prev_fall = fc;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (dl || er) break;
      end
      chk("latency", cyc - fc + 1, 133);
      chk("cs_n_at_pulse", int'(cs_n), 1);
      chk("datos_listos", int'(dl), exp_dl);
      chk("error_trama", int'(er), 1 - exp_dl);
      chk("temperatura", int'(temp), exp_t);
      chk("sclk_rises", nr - r0, 16);
      @(negedge clk);
      chk("pulse_width", int'({dl, er}), 0);
   endtask

   initial begin
      int c0;
      int fc;
      int r0;
      frame = 16'hFFFF;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_cs_n", int'(cs_n), 1);
      chk("rst_sclk", int'(sclk), 1);
      chk("rst_temp", int'(temp), 0);
      chk("rst_pulses", int'({dl, er}), 0);
      chk("rst_ocupado", int'(ocup), 0);
      rst = 1'b1;
      c0  = cyc;

      do_frame(3'b000, 8'hB7, c0, 1, 22);
      do_frame(3'b010, 8'hFF, prev_fall, 0, 22);
      do_frame(3'b000, 8'h00, prev_fall, 1, 0);
      do_frame(3'b000, 8'h07, prev_fall, 1, 0);
      do_frame(3'b000, 8'h08, prev_fall, 1, 1);
      do_frame(3'b000, 8'hFF, prev_fall, 1, 31);

      // abort on the clk edge that would make the 7th SCLK rise
      frame = {3'b000, 8'h33, 5'b00000};
      for (int k = 0; k < 1200; k++) begin
         @(negedge clk);
         if (!cs_n) break;
      end
      fc = cyc;
      r0 = nr;
      chk("mid_fall_gap", fc - prev_fall, 1000);
      repeat (55) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_cs_n", int'(cs_n), 1);
      chk("mid_sclk", int'(sclk), 1);
      chk("mid_pulses", int'({dl, er}), 0);
      chk("mid_rises", nr - r0, 6);
      chk("mid_temp", int'(temp), 0);
      @(negedge clk);
      rst = 1'b1;
      c0  = cyc;
      do_frame(3'b000, 8'h5A, c0, 1, 11);

      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (cs_n2) break;
      end
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!cs_n2) break;
      end
      fc = cyc;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (cs_n2) break;
      end
      chk("p2_cs_low", cyc - fc, 66);
      chk("p2_dl", int'(dl2), 1);
      chk("p2_err", int'(er2), 0);
      chk("p2_temp", int'(temp2), 16);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
